// File: rtl/instruction_decode.sv
// ID stage of the MIPS32 pipeline: register file, operand read, imm sign-extend, opcode class, ID_EX latch.
// Optional load-use interlock enabled by defining LOAD_USE_STALL_EN.
module instruction_decode #(
  parameter int                 DATA_W = 32,
  parameter int                 NREGS  = 32,
  parameter logic [DATA_W-1:0]  NOP_IR = 32'h0000_0000
) (
  input  logic                        clk2,
  input  logic                        rst_n,
  input  logic                        HALTED,
  input  logic                        TAKEN_BRANCH,
  input  logic [31:0]                 IF_ID_IR,
  input  logic [31:0]                 IF_ID_NPC,
  input  logic                        wb_we,
  input  logic [$clog2(NREGS)-1:0]    wb_addr,
  input  logic [DATA_W-1:0]           wb_data,
  output logic [31:0]                 ID_EX_IR,
  output logic [31:0]                 ID_EX_NPC,
  output logic [DATA_W-1:0]           ID_EX_A,
  output logic [DATA_W-1:0]           ID_EX_B,
  output logic [DATA_W-1:0]           ID_EX_Imm,
  output logic [2:0]                  ID_EX_type,
  output logic                        illegal_op,
  output logic                        id_stall
);

  localparam int AW = $clog2(NREGS);

  typedef enum logic [2:0] {
    T_RR_ALU  = 3'd0,
    T_RM_ALU  = 3'd1,
    T_LOAD    = 3'd2,
    T_STORE   = 3'd3,
    T_BRANCH  = 3'd4,
    T_HALT    = 3'd5,
    T_NOP     = 3'd6,
    T_ILLEGAL = 3'd7
  } itype_t;

  logic [DATA_W-1:0] regs [NREGS];

  logic [5:0]        opcode;
  logic [AW-1:0]     rs;
  logic [AW-1:0]     rt;
  itype_t            dec_type;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;
  logic [DATA_W-1:0] imm_ext;

  assign opcode  = IF_ID_IR[31:26];
  assign rs      = IF_ID_IR[21 +: AW];
  assign rt      = IF_ID_IR[16 +: AW];
  assign imm_ext = {{(DATA_W-16){IF_ID_IR[15]}}, IF_ID_IR[15:0]};

  always_comb begin
    dec_type = T_ILLEGAL;
    case (opcode)
      6'b000000, 6'b000001, 6'b000010,
      6'b000011, 6'b000100, 6'b000101: dec_type = T_RR_ALU;
      6'b001010, 6'b001011, 6'b001100: dec_type = T_RM_ALU;
      6'b001000:                       dec_type = T_LOAD;
      6'b001001:                       dec_type = T_STORE;
      6'b001101, 6'b001110:            dec_type = T_BRANCH;
      6'b111111:                       dec_type = T_HALT;
      default:                         dec_type = T_ILLEGAL;
    endcase
  end

  // R0 is hard zero; a same-edge WB write to the addressed register is forwarded.
  always_comb begin
    rd_a = '0;
    rd_b = '0;
    if (rs != '0) rd_a = (wb_we && (wb_addr == rs)) ? wb_data : regs[rs];
    if (rt != '0) rd_b = (wb_we && (wb_addr == rt)) ? wb_data : regs[rt];
  end

`ifdef LOAD_USE_STALL_EN
  logic [4:0] ld_dst;
  logic       uses_rt;

  assign ld_dst  = ID_EX_IR[20:16];
  assign uses_rt = (dec_type == T_RR_ALU) || (dec_type == T_STORE) || (dec_type == T_BRANCH);
  assign id_stall = !HALTED && !TAKEN_BRANCH &&
                    (ID_EX_type == T_LOAD) && (ld_dst != 5'd0) &&
                    ((ld_dst == IF_ID_IR[25:21]) || (uses_rt && (ld_dst == IF_ID_IR[20:16])));
`else
  assign id_stall = 1'b0;
`endif

  always_ff @(posedge clk2 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_we && (wb_addr != '0)) begin
      regs[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk2 or negedge rst_n) begin
    if (!rst_n) begin
      ID_EX_IR   <= '0;
      ID_EX_NPC  <= '0;
      ID_EX_A    <= '0;
      ID_EX_B    <= '0;
      ID_EX_Imm  <= '0;
      ID_EX_type <= T_NOP;
      illegal_op <= 1'b0;
    end else if (HALTED) begin
      ID_EX_IR   <= ID_EX_IR;
    end else if (TAKEN_BRANCH || id_stall) begin
      // Bubble keeps NPC so downstream PC bookkeeping stays consistent.
      ID_EX_IR   <= NOP_IR;
      ID_EX_NPC  <= IF_ID_NPC;
      ID_EX_A    <= '0;
      ID_EX_B    <= '0;
      ID_EX_Imm  <= '0;
      ID_EX_type <= T_NOP;
    end else begin
      ID_EX_IR   <= IF_ID_IR;
      ID_EX_NPC  <= IF_ID_NPC;
      ID_EX_A    <= rd_a;
      ID_EX_B    <= rd_b;
      ID_EX_Imm  <= imm_ext;
      ID_EX_type <= dec_type;
      if (dec_type == T_ILLEGAL) illegal_op <= 1'b1;
    end
  end

endmodule
